ysyx_25020037_exu_issue: RTL and testbench
==========================================

YSYX_25020037_EXU_ISSUE -- requirements
Module: ysyx_25020037_exu_issue

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; all state updates on the rising edge of clock only.
REQ-002 SHALL expose these ports (name  direction  width  meaning):
- clock  in  1  sole clock
- reset_n  in  1  synchronous active-low reset
- id_valid  in  1  decoded instruction offered
- id_ready  out  1  block accepts this cycle
- id_pc  in  32  instruction PC
- id_rs1  in  32  rs1 value
- id_rs2  in  32  rs2 value
- id_imm  in  32  sign-extended immediate
- id_fn  in  5  op code 0..16, same bit order as alu_op (0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 or, 6 xor, 7 sll, 8 srl, 9 sra, 10 lui, 11 bne, 12 beq, 13 bge, 14 bgeu, 15 blt, 16 bltu)
- id_src2_imm  in  1  src2 = imm, else rs2
- id_src1_pc  in  1  src1 = pc, else rs1
- id_jal  in  1  JAL
- id_jalr  in  1  JALR
- id_rd  in  5  destination register
- alu_op  out  17  one-hot op to ALU
- double_cal  out  1  branch mode to ALU
- alu_src1..alu_src4  out  32 each  ALU operands
- alu_result1  in  32  ALU arithmetic result
- alu_result2  in  1  ALU branch condition
- ex_valid  out  1  result valid to next stage
- ex_ready  in  1  next stage accepts
- ex_result  out  32  writeback value
- ex_rd  out  5  writeback register (0 = none)
- ex_pc  out  32  PC of the result
- redirect_valid  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  32  redirect target
- taken_cnt  out  32  count of redirects issued

Function
REQ-003 SHALL drive the ALU combinationally from id_* in the accept cycle; ALU outputs are captured into the output register at the same edge; latency is 1 cycle from accept to ex_valid.
REQ-004 SHALL assert id_ready = (~ex_valid | ex_ready) & ~redirect_valid.
REQ-005 SHALL define accept = id_valid & id_ready; on accept set ex_valid=1; otherwise, when ex_ready=1, clear ex_valid.
REQ-006 SHALL hold ex_result, ex_rd and ex_pc stable while ex_valid=1 & ex_ready=0.
REQ-007 SHALL operate as a 2-state FSM, EMPTY/FULL, with FULL == ex_valid:
- EMPTY->FULL on accept
- FULL->EMPTY on ex_ready & ~accept
- FULL->FULL on accept & ex_ready
REQ-008 ALU ops (fn 0..10), no jump: alu_op = onehot(fn); double_cal=0; src1 = id_src1_pc ? pc : rs1; src2 = id_src2_imm ? imm : rs2; src3=src4=0; ex_result=alu_result1; ex_rd=id_rd.
REQ-009 Branch (fn 11..16): alu_op = onehot(fn) | bit0; double_cal=1; src1=pc, src2=imm, src3=rs1, src4=rs2; ex_rd=0; ex_result=0; if alu_result2=1, pulse redirect with redirect_pc=alu_result1.
REQ-010 JAL/JALR: alu_op=bit0, double_cal=0; src1 = jalr ? rs1 : pc; src2=imm; ex_result=pc+4 (mod 2^32); ex_rd=id_rd; always redirect, with redirect_pc = alu_result1 & 32'hFFFF_FFFE.
REQ-011 SHALL raise redirect_valid for exactly the cycle after the redirecting accept; it is never held by ex_ready.
REQ-012 id_fn > 16 (non-jump) SHALL yield alu_op=0, ex_result=0, ex_rd=0, no redirect.
REQ-013 SHALL increment taken_cnt by 1 per redirect pulse, wrapping 32'hFFFF_FFFF->0.
REQ-014 SHALL drive alu_* outputs regardless of id_valid; results are used only on accept.

Reset
REQ-015 SHALL, on reset_n=0 at a clock edge, set ex_valid=0, redirect_valid=0, ex_result=0, ex_rd=0, ex_pc=0, redirect_pc=0, taken_cnt=0, FSM=EMPTY.
REQ-016 SHALL let reset mid-operation discard the held result and any pending redirect; the first accept is possible in the cycle after reset_n rises.

Verification
REQ-017 add: rs1=5, rs2=7, fn=0, rd=3, ex_ready=1 -> next cycle ex_valid=1, ex_result=12, ex_rd=3, redirect_valid=0.
REQ-018 beq taken: pc=0x8000_0010, imm=0xFFFF_FFF0, rs1=rs2=9 -> redirect_valid pulse with redirect_pc=0x8000_0000, ex_rd=0, taken_cnt=1; id_ready=0 during the pulse.
REQ-019 bltu not taken: rs1=0xFFFF_FFFF, rs2=1 -> no redirect, taken_cnt unchanged.
REQ-020 jalr: rs1=0x8000_0101, imm=4, pc=0x8000_0020, rd=1 -> ex_result=0x8000_0024, redirect_pc=0x8000_0104.
REQ-021 backpressure: ex_ready=0 for 3 cycles after accept -> ex_* stable, id_ready=0; ex_ready=1 with id_valid=1 -> back-to-back accept with no bubble.
REQ-022 reset while FULL with a redirect pending, and taken_cnt preset to 0xFFFF_FFFF then a redirect -> all REQ-015 values; taken_cnt wraps to 0.

Source files
------------

// File: rtl/ysyx_25020037_exu_issue.sv
// ysyx_25020037_exu_issue: single-entry issue stage between decode and ALU.
// Steers operands to the ALU, registers the result and pulses fetch redirects.
module ysyx_25020037_exu_issue (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1,
  input  logic [31:0] id_rs2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_fn,
  input  logic        id_src2_imm,
  input  logic        id_src1_pc,
  input  logic        id_jal,
  input  logic        id_jalr,
  input  logic [4:0]  id_rd,
  output logic [16:0] alu_op,
  output logic        double_cal,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [31:0] alu_src3,
  output logic [31:0] alu_src4,
  input  logic [31:0] alu_result1,
  input  logic        alu_result2,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_result,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_pc,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] taken_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  logic        is_jump;
  logic        is_br;
  logic        is_alu;
  logic [16:0] fn_hot;
  logic        accept;

  logic [31:0] res_d;
  logic [31:0] tgt_d;
  logic [4:0]  rd_d;
  logic        redir_d;

  assign is_jump = id_jal | id_jalr;
  assign is_br   = ~is_jump & (id_fn >= 5'd11) & (id_fn <= 5'd16);
  assign is_alu  = ~is_jump & (id_fn <= 5'd10);
  assign fn_hot  = 17'd1 << id_fn;

  assign ex_valid = (state == FULL);
  assign id_ready = (~ex_valid | ex_ready) & ~redirect_valid;
  assign accept   = id_valid & id_ready;

  // Operand steering depends only on id_* so the ALU sees it every cycle.
  always_comb begin
    alu_op     = '0;
    double_cal = 1'b0;
    alu_src1   = id_src1_pc ? id_pc : id_rs1;
    alu_src2   = id_src2_imm ? id_imm : id_rs2;
    alu_src3   = '0;
    alu_src4   = '0;
    unique case (1'b1)
      is_jump: begin
        alu_op   = 17'd1;
        alu_src1 = id_jalr ? id_rs1 : id_pc;
        alu_src2 = id_imm;
      end
      is_br: begin
        alu_op     = fn_hot | 17'd1;
        double_cal = 1'b1;
        alu_src1   = id_pc;
        alu_src2   = id_imm;
        alu_src3   = id_rs1;
        alu_src4   = id_rs2;
      end
      is_alu: alu_op = fn_hot;
      default: alu_op = '0;
    endcase
  end

  always_comb begin
    res_d   = '0;
    rd_d    = '0;
    redir_d = 1'b0;
    tgt_d   = alu_result1;
    unique case (1'b1)
      is_jump: begin
        res_d   = id_pc + 32'd4;
        rd_d    = id_rd;
        redir_d = 1'b1;
        tgt_d   = alu_result1 & 32'hFFFF_FFFE;
      end
      is_br: redir_d = alu_result2;
      is_alu: begin
        res_d = alu_result1;
        rd_d  = id_rd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: if (accept) state_nx = FULL;
      FULL: begin
        if (accept)        state_nx = FULL;
        else if (ex_ready) state_nx = EMPTY;
      end
      default: state_nx = EMPTY;
    endcase
  end

  // The redirect pulse lasts one cycle and blocks id_ready while it is up.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ex_result      <= '0;
      ex_rd          <= '0;
      ex_pc          <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      taken_cnt      <= '0;
    end else begin
      redirect_valid <= accept & redir_d;
      if (accept) begin
        ex_result <= res_d;
        ex_rd     <= rd_d;
        ex_pc     <= id_pc;
      end
      if (accept & redir_d) begin
        redirect_pc <= tgt_d;
        taken_cnt   <= taken_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_exu_issue.sv
// tb_ysyx_25020037_exu_issue: vector table, corner sequences and random
// traffic against a transaction-level model of the issue stage.
module tb_ysyx_25020037_exu_issue;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_rs1, id_rs2, id_imm;
  logic [4:0]  id_fn, id_rd;
  logic        id_src2_imm, id_src1_pc, id_jal, id_jalr;
  logic [16:0] alu_op;
  logic        double_cal;
  logic [31:0] alu_src1, alu_src2, alu_src3, alu_src4;
  logic [31:0] alu_result1;
  logic        alu_result2;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_result, ex_pc;
  logic [4:0]  ex_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc, taken_cnt;

  always #5 clock = ~clock;

  ysyx_25020037_exu_issue dut (
    .clock(clock), .reset_n(reset_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm(id_imm),
    .id_fn(id_fn), .id_src2_imm(id_src2_imm), .id_src1_pc(id_src1_pc),
    .id_jal(id_jal), .id_jalr(id_jalr), .id_rd(id_rd),
    .alu_op(alu_op), .double_cal(double_cal),
    .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_src3(alu_src3), .alu_src4(alu_src4),
    .alu_result1(alu_result1), .alu_result2(alu_result2),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_result(ex_result), .ex_rd(ex_rd), .ex_pc(ex_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .taken_cnt(taken_cnt)
  );

  // Stand-in ALU driven by the DUT's one-hot op.
  always_comb begin
    alu_result1 = '0;
    alu_result2 = 1'b0;
    if (double_cal) begin
      alu_result1 = alu_src1 + alu_src2;
      if (alu_op[11])      alu_result2 = alu_src3 != alu_src4;
      else if (alu_op[12]) alu_result2 = alu_src3 == alu_src4;
      else if (alu_op[13]) alu_result2 = $signed(alu_src3) >= $signed(alu_src4);
      else if (alu_op[14]) alu_result2 = alu_src3 >= alu_src4;
      else if (alu_op[15]) alu_result2 = $signed(alu_src3) < $signed(alu_src4);
      else if (alu_op[16]) alu_result2 = alu_src3 < alu_src4;
    end else begin
      if (alu_op[0])       alu_result1 = alu_src1 + alu_src2;
      else if (alu_op[1])  alu_result1 = alu_src1 - alu_src2;
      else if (alu_op[2])  alu_result1 = {31'b0, $signed(alu_src1) < $signed(alu_src2)};
      else if (alu_op[3])  alu_result1 = {31'b0, alu_src1 < alu_src2};
      else if (alu_op[4])  alu_result1 = alu_src1 & alu_src2;
      else if (alu_op[5])  alu_result1 = alu_src1 | alu_src2;
      else if (alu_op[6])  alu_result1 = alu_src1 ^ alu_src2;
      else if (alu_op[7])  alu_result1 = alu_src1 << alu_src2[4:0];
      else if (alu_op[8])  alu_result1 = alu_src1 >> alu_src2[4:0];
      else if (alu_op[9])  alu_result1 = $signed(alu_src1) >>> alu_src2[4:0];
      else if (alu_op[10]) alu_result1 = alu_src2;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  fn;
    logic [31:0] pc, rs1, rs2, imm;
    logic        s1pc, s2imm, jal, jalr;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [4:0]  erd;
    logic        redir;
    logic [31:0] rpc;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        redir;
    logic [31:0] tgt;
  } exp_t;

  function automatic exp_t ref_calc(input logic [4:0] fn, input logic [31:0] pc,
      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
      input logic s1pc, input logic s2imm, input logic jal, input logic jalr,
      input logic [4:0] rd);
    exp_t e;
    logic [31:0] a, b;
    e = '{default: '0};
    a = s1pc ? pc : rs1;
    b = s2imm ? imm : rs2;
    if (jal || jalr) begin
      e.res = pc + 32'd4;
      e.rd = rd;
      e.redir = 1'b1;
      e.tgt = ((jalr ? rs1 : pc) + imm) & 32'hFFFF_FFFE;
    end else if (fn <= 5'd10) begin
      e.rd = rd;
      case (fn)
        5'd0: e.res = a + b;
        5'd1: e.res = a - b;
        5'd2: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        5'd3: e.res = (a < b) ? 32'd1 : 32'd0;
        5'd4: e.res = a & b;
        5'd5: e.res = a | b;
        5'd6: e.res = a ^ b;
        5'd7: e.res = a << b[4:0];
        5'd8: e.res = a >> b[4:0];
        5'd9: e.res = 32'($signed(a) >>> b[4:0]);
        default: e.res = b;
      endcase
    end else if (fn <= 5'd16) begin
      case (fn)
        5'd11: e.redir = rs1 != rs2;
        5'd12: e.redir = rs1 == rs2;
        5'd13: e.redir = $signed(rs1) >= $signed(rs2);
        5'd14: e.redir = rs1 >= rs2;
        5'd15: e.redir = $signed(rs1) < $signed(rs2);
        default: e.redir = rs1 < rs2;
      endcase
      e.tgt = pc + imm;
    end
    return e;
  endfunction

  task automatic set_vec(input vec_t v);
    id_fn = v.fn; id_pc = v.pc; id_rs1 = v.rs1; id_rs2 = v.rs2;
    id_imm = v.imm; id_src1_pc = v.s1pc; id_src2_imm = v.s2imm;
    id_jal = v.jal; id_jalr = v.jalr; id_rd = v.rd;
  endtask

  vec_t vt[15];
  logic [31:0] exp_cnt;
  logic        m_valid, m_rv, acc, exp_ready, rst, bad;
  logic [31:0] m_res, m_pc, m_rpc, m_cnt;
  logic [4:0]  m_rd;
  logic [16:0] eop;
  logic [31:0] es1, es2, es3, es4;
  exp_t        e;

  initial begin
    vt[0]  = '{5'd0,  32'h0000_0100, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3,
               32'd12, 5'd3, 1'b0, 32'd0};
    vt[1]  = '{5'd12, 32'h8000_0010, 32'd9, 32'd9, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7,
               32'd0, 5'd0, 1'b1, 32'h8000_0000};
    vt[2]  = '{5'd16, 32'h8000_0040, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5,
               32'd0, 5'd0, 1'b0, 32'd0};
    vt[3]  = '{5'd0,  32'h8000_0020, 32'h8000_0101, 32'd0, 32'd4, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1,
               32'h8000_0024, 5'd1, 1'b1, 32'h8000_0104};
    vt[4]  = '{5'd1,  32'h0000_0200, 32'd10, 32'd99, 32'd3, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4,
               32'd7, 5'd4, 1'b0, 32'd0};
    vt[5]  = '{5'd2,  32'h0000_0204, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6,
               32'd1, 5'd6, 1'b0, 32'd0};
    vt[6]  = '{5'd3,  32'h0000_0208, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6,
               32'd0, 5'd6, 1'b0, 32'd0};
    vt[7]  = '{5'd0,  32'h0000_1000, 32'd55, 32'd66, 32'h2000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8,
               32'h3000, 5'd8, 1'b0, 32'd0};
    vt[8]  = '{5'd10, 32'h0000_1004, 32'd77, 32'd88, 32'h1234_5000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9,
               32'h1234_5000, 5'd9, 1'b0, 32'd0};
    vt[9]  = '{5'd9,  32'h0000_1008, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10,
               32'hF800_0000, 5'd10, 1'b0, 32'd0};
    vt[10] = '{5'd20, 32'h0000_100C, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd11,
               32'd0, 5'd0, 1'b0, 32'd0};
    vt[11] = '{5'd12, 32'h0000_0100, 32'd3, 32'd3, 32'hFFFF_FF00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1,
               32'h0000_0104, 5'd1, 1'b1, 32'h0000_0000};
    vt[12] = '{5'd15, 32'h0000_0200, 32'hFFFF_FFFE, 32'd3, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2,
               32'd0, 5'd0, 1'b1, 32'h0000_0240};
    vt[13] = '{5'd13, 32'h0000_0300, 32'hFFFF_FFFE, 32'd3, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2,
               32'd0, 5'd0, 1'b0, 32'd0};
    vt[14] = '{5'd11, 32'hFFFF_FFF0, 32'd1, 32'd2, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2,
               32'd0, 5'd0, 1'b1, 32'h0000_0010};

    id_valid = 1'b0; ex_ready = 1'b1;
    set_vec(vt[0]);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
    chk("rst_ex_result", ex_result, 32'd0);
    chk("rst_ex_rd", {27'b0, ex_rd}, 32'd0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_taken_cnt", taken_cnt, 32'd0);
    reset_n = 1'b1;

    exp_cnt = 32'd0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      set_vec(vt[i]);
      id_valid = 1'b1; ex_ready = 1'b1;
      #1 chk($sformatf("tbl%0d_id_ready", i), {31'b0, id_ready}, 32'd1);
      @(negedge clock);
      id_valid = 1'b0;
      #1;
      chk($sformatf("tbl%0d_ex_valid", i), {31'b0, ex_valid}, 32'd1);
      chk($sformatf("tbl%0d_ex_result", i), ex_result, vt[i].res);
      chk($sformatf("tbl%0d_ex_rd", i), {27'b0, ex_rd}, {27'b0, vt[i].erd});
      chk($sformatf("tbl%0d_ex_pc", i), ex_pc, vt[i].pc);
      chk($sformatf("tbl%0d_redirect", i), {31'b0, redirect_valid}, {31'b0, vt[i].redir});
      if (vt[i].redir) chk($sformatf("tbl%0d_redirect_pc", i), redirect_pc, vt[i].rpc);
      chk($sformatf("tbl%0d_id_ready_pulse", i), {31'b0, id_ready}, {31'b0, ~vt[i].redir});
      exp_cnt = exp_cnt + {31'b0, vt[i].redir};
      chk($sformatf("tbl%0d_taken_cnt", i), taken_cnt, exp_cnt);
    end

    // Backpressure: result held for three stalled cycles, then no bubble.
    @(negedge clock);
    set_vec(vt[0]); id_rs1 = 32'd1; id_rs2 = 32'd2; id_rd = 5'd2;
    id_valid = 1'b1; ex_ready = 1'b0;
    #1 chk("bp_first_ready", {31'b0, id_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      id_rs1 = 32'd100 + k;
      #1;
      chk($sformatf("bp%0d_ex_valid", k), {31'b0, ex_valid}, 32'd1);
      chk($sformatf("bp%0d_ex_result", k), ex_result, 32'd3);
      chk($sformatf("bp%0d_ex_rd", k), {27'b0, ex_rd}, 32'd2);
      chk($sformatf("bp%0d_id_ready", k), {31'b0, id_ready}, 32'd0);
    end
    @(negedge clock);
    id_rs1 = 32'd10; id_rs2 = 32'd20; id_rd = 5'd3; ex_ready = 1'b1;
    #1 chk("bp_release_ready", {31'b0, id_ready}, 32'd1);
    chk("bp_release_hold", ex_result, 32'd3);
    @(negedge clock);
    id_valid = 1'b0;
    #1 chk("bp_b2b_valid", {31'b0, ex_valid}, 32'd1);
    chk("bp_b2b_result", ex_result, 32'd30);
    chk("bp_b2b_rd", {27'b0, ex_rd}, 32'd3);
    @(negedge clock);
    #1 chk("bp_drain", {31'b0, ex_valid}, 32'd0);

    // Reset while full with a redirect pulse outstanding.
    @(negedge clock);
    set_vec(vt[11]);
    id_valid = 1'b1; ex_ready = 1'b0;
    @(negedge clock);
    id_valid = 1'b0;
    #1 chk("mr_pending", {31'b0, redirect_valid}, 32'd1);
    chk("mr_full", {31'b0, ex_valid}, 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("mr_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("mr_redirect_valid", {31'b0, redirect_valid}, 32'd0);
    chk("mr_ex_result", ex_result, 32'd0);
    chk("mr_ex_rd", {27'b0, ex_rd}, 32'd0);
    chk("mr_ex_pc", ex_pc, 32'd0);
    chk("mr_redirect_pc", redirect_pc, 32'd0);
    chk("mr_taken_cnt", taken_cnt, 32'd0);
    chk("mr_id_ready", {31'b0, id_ready}, 32'd1);
    set_vec(vt[0]);
    id_valid = 1'b1; ex_ready = 1'b1;
    @(negedge clock);
    id_valid = 1'b0;
    #1 chk("mr_first_accept", {31'b0, ex_valid}, 32'd1);
    chk("mr_first_result", ex_result, 32'd12);

    // Counter wrap from all-ones.
    @(negedge clock);
    force dut.taken_cnt = 32'hFFFF_FFFF;
    #1 release dut.taken_cnt;
    #1 chk("wrap_preset", taken_cnt, 32'hFFFF_FFFF);
    @(negedge clock);
    set_vec(vt[3]);
    id_valid = 1'b1;
    @(negedge clock);
    id_valid = 1'b0;
    #1 chk("wrap_pulse", {31'b0, redirect_valid}, 32'd1);
    chk("wrap_cnt", taken_cnt, 32'd0);
    chk("wrap_rpc", redirect_pc, 32'h8000_0104);

    // Random traffic against the transaction model.
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    m_valid = 1'b0; m_rv = 1'b0; m_res = '0; m_rd = '0;
    m_pc = '0; m_rpc = '0; m_cnt = '0;
    for (int n = 0; n < 3000; n++) begin
      id_fn = 5'($urandom_range(0, 19));
      id_pc = $urandom;
      id_rs1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      id_rs2 = ($urandom_range(0, 2) == 0) ? id_rs1 : $urandom;
      id_imm = $urandom;
      id_src1_pc = 1'($urandom_range(0, 1));
      id_src2_imm = 1'($urandom_range(0, 1));
      id_jal = ($urandom_range(0, 9) == 0);
      id_jalr = ($urandom_range(0, 9) == 0);
      id_rd = 5'($urandom);
      id_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 149) == 0);
      reset_n = ~rst;
      #1;
      exp_ready = (!m_valid || ex_ready) && !m_rv;
      chk("rnd_id_ready", {31'b0, id_ready}, {31'b0, exp_ready});
      chk("rnd_ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
      chk("rnd_redirect_valid", {31'b0, redirect_valid}, {31'b0, m_rv});
      chk("rnd_redirect_pc", redirect_pc, m_rpc);
      chk("rnd_taken_cnt", taken_cnt, m_cnt);
      chk("rnd_ex_result", ex_result, m_res);
      chk("rnd_ex_rd", {27'b0, ex_rd}, {27'b0, m_rd});
      chk("rnd_ex_pc", ex_pc, m_pc);
      bad = 1'b0;
      es3 = '0; es4 = '0;
      es1 = id_src1_pc ? id_pc : id_rs1;
      es2 = id_src2_imm ? id_imm : id_rs2;
      if (id_jal || id_jalr) begin
        eop = 17'd1;
        es1 = id_jalr ? id_rs1 : id_pc;
        es2 = id_imm;
      end else if (id_fn <= 5'd10) begin
        eop = 17'd1 << id_fn;
      end else if (id_fn <= 5'd16) begin
        eop = (17'd1 << id_fn) | 17'd1;
        es1 = id_pc; es2 = id_imm; es3 = id_rs1; es4 = id_rs2;
      end else begin
        eop = '0;
        bad = 1'b1;
      end
      chk("rnd_alu_op", {15'b0, alu_op}, {15'b0, eop});
      chk("rnd_double_cal", {31'b0, double_cal}, {31'b0, es3 != '0 || es4 != '0 ||
          (!(id_jal || id_jalr) && id_fn >= 5'd11 && id_fn <= 5'd16)});
      if (!bad) begin
        chk("rnd_src1", alu_src1, es1);
        chk("rnd_src2", alu_src2, es2);
        chk("rnd_src3", alu_src3, es3);
        chk("rnd_src4", alu_src4, es4);
      end
      if (rst) begin
        m_valid = 1'b0; m_rv = 1'b0; m_res = '0; m_rd = '0;
        m_pc = '0; m_rpc = '0; m_cnt = '0;
      end else begin
        acc = id_valid && exp_ready;
        if (acc) begin
          e = ref_calc(id_fn, id_pc, id_rs1, id_rs2, id_imm, id_src1_pc,
                       id_src2_imm, id_jal, id_jalr, id_rd);
          m_valid = 1'b1;
          m_res = e.res;
          m_rd = e.rd;
          m_pc = id_pc;
          m_rv = e.redir;
          if (e.redir) begin
            m_rpc = e.tgt;
            m_cnt = m_cnt + 32'd1;
          end
        end else begin
          m_rv = 1'b0;
          if (ex_ready) m_valid = 1'b0;
        end
      end
      @(negedge clock);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
